divclk_window_ctrl: RTL and testbench

Controller for the team's programmable clock-divider resource in the PUF measurement path. Holds the active divisor and accepts new divisors over a valid/ready handshake. Applies a new divisor only at a half-period boundary, so ClkOut never has a runt pulse. Sequences a measurement gate that stays open for exactly N divided-clock periods; the ring-oscillator counters use that gate as their sampling window.

---
 rtl/divclk_window_ctrl_pkg.sv | 8 +
 rtl/divclk_window_ctrl_if.sv | 30 +++
 rtl/divclk_window_ctrl_div_core.sv | 50 +++++
 rtl/divclk_window_ctrl.sv | 96 +++++++++
 tb/tb_divclk_window_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/divclk_window_ctrl_pkg.sv
// Shared types and default sizing for the PUF clock-divider window controller.
package puf_clk_pkg;
  localparam int DFLT_CNT_W = 25;
  localparam int DFLT_WIN_W = 16;
  localparam int DFLT_DIV   = 25000;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} winState_e;
endpackage

// File: rtl/divclk_window_ctrl_if.sv
// Config handshake, window control and divided-clock outputs of the window controller.
interface divclk_window_ctrl_if
  import puf_clk_pkg::*;
#(
  parameter int CNT_W = DFLT_CNT_W,
  parameter int WIN_W = DFLT_WIN_W
);
  logic             CfgValid;
  logic [CNT_W-1:0] CfgDiv;
  logic             CfgReady;
  logic             Start;
  logic [WIN_W-1:0] WinTicks;
  logic             Abort;
  logic             ClkOut;
  logic             Tick;
  logic             Gate;
  logic             Busy;
  logic             Done;
  logic [WIN_W-1:0] TickCount;

  modport master (
    output CfgValid, CfgDiv, Start, WinTicks, Abort,
    input  CfgReady, ClkOut, Tick, Gate, Busy, Done, TickCount
  );

  modport slave (
    input  CfgValid, CfgDiv, Start, WinTicks, Abort,
    output CfgReady, ClkOut, Tick, Gate, Busy, Done, TickCount
  );
endinterface

// File: rtl/divclk_window_ctrl_div_core.sv
// Free-running divider: half-period = active divisor + 1 Clk cycles, with a
// pending divisor that is only swapped in at terminal count (no runt pulses).
module div_core #(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 25000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             CfgLoad,
  input  logic [CNT_W-1:0] CfgDiv,
  output logic             ClkOut,
  output logic             Tick,
  output logic             Pending
);
  logic [CNT_W-1:0] divCnt;
  logic [CNT_W-1:0] activeDiv;
  logic [CNT_W-1:0] pendDiv;
  logic             tc;

  assign tc = (divCnt == activeDiv);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      divCnt    <= '0;
      activeDiv <= CNT_W'(DEFAULT_DIV);
      pendDiv   <= '0;
      Pending   <= 1'b0;
      ClkOut    <= 1'b0;
      Tick      <= 1'b0;
    end else begin
      // Tick lines up with the first cycle ClkOut reads high.
      Tick <= tc && !ClkOut;
      if (tc) begin
        divCnt <= '0;
        ClkOut <= ~ClkOut;
        if (Pending) begin
          activeDiv <= pendDiv;
          Pending   <= 1'b0;
        end
      end else begin
        divCnt <= divCnt + CNT_W'(1);
      end
      // A load is only offered while nothing is pending, so it never races the swap.
      if (CfgLoad) begin
        pendDiv <= CfgDiv;
        Pending <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/divclk_window_ctrl.sv
// Divisor handshake plus measurement-gate sequencer: Gate stays open for exactly
// WinTicks divided-clock periods, starting one Clk after a ClkOut rising edge.
module divclk_window_ctrl
  import puf_clk_pkg::*;
#(
  parameter int CNT_W       = DFLT_CNT_W,
  parameter int DEFAULT_DIV = DFLT_DIV,
  parameter int WIN_W       = DFLT_WIN_W
) (
  input logic                Clk,
  input logic                Rst_n,
  divclk_window_ctrl_if.slave Bus
);
  winState_e        state;
  logic [WIN_W-1:0] winLen;
  logic [WIN_W-1:0] tickCount;
  logic [WIN_W-1:0] tickNext;
  logic             gate;
  logic             done;
  logic             tick;
  logic             clkOut;
  logic             pending;
  logic             idleLike;
  logic             cfgReady;
  logic             cfgLoad;

  div_core #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) uDivCore (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .CfgLoad(cfgLoad),
    .CfgDiv (Bus.CfgDiv),
    .ClkOut (clkOut),
    .Tick   (tick),
    .Pending(pending)
  );

  assign idleLike = (state == IDLE) || (state == DONE);
  assign cfgReady = idleLike && !pending;
  assign cfgLoad  = Bus.CfgValid && cfgReady;
  assign tickNext = tickCount + WIN_W'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      winLen    <= '0;
      tickCount <= '0;
      gate      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (Bus.Start && !Bus.Abort && (Bus.WinTicks != '0)) begin
            winLen    <= Bus.WinTicks;
            tickCount <= '0;
            state     <= ARM;
          end
        end
        ARM: begin
          // The arming tick only aligns the window; it is not counted.
          if (Bus.Abort) begin
            state <= IDLE;
          end else if (tick) begin
            state <= RUN;
            gate  <= 1'b1;
          end
        end
        RUN: begin
          if (Bus.Abort) begin
            state <= IDLE;
            gate  <= 1'b0;
          end else if (tick) begin
            tickCount <= tickNext;
            if (tickNext == winLen) begin
              state <= DONE;
              gate  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Bus.CfgReady  = cfgReady;
  assign Bus.ClkOut    = clkOut;
  assign Bus.Tick      = tick;
  assign Bus.Gate      = gate;
  assign Bus.Busy      = (state == ARM) || (state == RUN);
  assign Bus.Done      = done;
  assign Bus.TickCount = tickCount;
endmodule

// File: tb/tb_divclk_window_ctrl.sv
// Bench for divclk_window_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a half-period/window model.
module tb_divclk_window_ctrl;
  localparam int CNT_W = 25;
  localparam int WIN_W = 16;
  localparam int DIV0  = 3;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  divclk_window_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  divclk_window_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DIV0),
    .WIN_W      (WIN_W)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Bus  (bus)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: ClkOut level flips after each half-period of (div+1) cycles; new divisors
  // take over at a flip. Window: armed -> running after a rising edge, counts rising edges.
  int mAge, mDiv, mPendDiv, mCnt, mTgt;
  bit mPend, mLvl, mTick, mArm, mRun, mDone;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mAge = 0; mDiv = DIV0; mPendDiv = 0; mPend = 0;
      mLvl = 0; mTick = 0; mArm = 0; mRun = 0; mDone = 0; mCnt = 0; mTgt = 0;
    end else begin
      bit rdy, tk;
      rdy = !mArm && !mRun && !mPend;
      tk = mTick;
      mTick = 0;
      mAge++;
      if (mAge == mDiv + 1) begin
        mAge = 0;
        mLvl = !mLvl;
        mTick = mLvl;
        if (mPend) begin mDiv = mPendDiv; mPend = 0; end
      end
      if (bus.CfgValid && rdy) begin mPend = 1; mPendDiv = int'(bus.CfgDiv); end
      mDone = 0;
      if (mArm || mRun) begin
        if (bus.Abort) begin mArm = 0; mRun = 0; end
        else if (mArm && tk) begin mArm = 0; mRun = 1; end
        else if (mRun && tk) begin
          mCnt++;
          if (mCnt == mTgt) begin mRun = 0; mDone = 1; end
        end
      end else if (bus.Start && !bus.Abort && bus.WinTicks != 0) begin
        mArm = 1; mTgt = int'(bus.WinTicks); mCnt = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("model ClkOut",    bus.ClkOut,    mLvl);
      chk("model Tick",      bus.Tick,      mTick);
      chk("model Gate",      bus.Gate,      mRun);
      chk("model Busy",      bus.Busy,      mArm || mRun);
      chk("model Done",      bus.Done,      mDone);
      chk("model TickCount", bus.TickCount, mCnt);
      chk("model CfgReady",  bus.CfgReady,  !mArm && !mRun && !mPend);
    end
  end

  task automatic waitTick(input string nm, output int at);
    int n = 0;
    do begin @(negedge Clk); n++; end while (bus.Tick !== 1'b1 && n < 300);
    if (bus.Tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: no Tick within 300 cycles", nm);
    end
    at = cyc;
  endtask

  task automatic waitGate(input logic lvl, input string nm);
    int n = 0;
    while (bus.Gate !== lvl && n < 300) begin @(negedge Clk); n++; end
    if (bus.Gate !== lvl) begin
      checks++; errors++;
      $display("FAIL %s: Gate never reached %0d", nm, lvl);
    end
  endtask

  task automatic measurePeriod(input string nm, output int per, output int hi);
    int t0, n;
    waitTick(nm, t0);
    hi = 1; n = 0;
    do begin
      @(negedge Clk); n++;
      if (bus.Tick !== 1'b1) hi += int'(bus.ClkOut);
    end while (bus.Tick !== 1'b1 && n < 300);
    per = cyc - t0;
  endtask

  task automatic gateWindow(input int injAt, output int len, output bit doneFall, output bit rdySeen);
    waitGate(1'b1, "window open");
    len = 0; rdySeen = 0;
    while (bus.Gate === 1'b1 && len < 500) begin
      len++;
      rdySeen |= bus.CfgReady;
      if (len == injAt) begin bus.Start = 1'b1; bus.WinTicks = 7; end
      else if (len == injAt + 1) bus.Start = 1'b0;
      @(negedge Clk);
    end
    doneFall = bus.Done;
  endtask

  task automatic pulseStart(input int w);
    @(negedge Clk);
    bus.Start = 1'b1; bus.WinTicks = WIN_W'(w);
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic loadDiv(input int d);
    @(negedge Clk);
    bus.CfgValid = 1'b1; bus.CfgDiv = CNT_W'(d);
    @(negedge Clk);
    bus.CfgValid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, hi, t0, t1, t2, len;
    bit dn, rs;
    bus.CfgValid = 0; bus.CfgDiv = '0; bus.Start = 0; bus.WinTicks = '0; bus.Abort = 0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Reset state and free-running period with div=3.
    chk("reset CfgReady", bus.CfgReady, 1);
    chk("reset Gate", bus.Gate, 0);
    chk("reset Busy", bus.Busy, 0);
    chk("reset TickCount", bus.TickCount, 0);
    measurePeriod("div3 period", per, hi);
    chk("div3 period", per, 8);
    chk("div3 high cycles", hi, 4);

    // Divisor change mid high half: 4 high + 2 low, then period 4.
    waitTick("cfg align", t0);
    @(negedge Clk);
    bus.CfgValid = 1'b1; bus.CfgDiv = 1;
    @(negedge Clk);
    bus.CfgValid = 1'b0;
    chk("CfgReady low while pending", bus.CfgReady, 0);
    waitTick("swap tick", t1);
    chk("transition period", t1 - t0, 6);
    chk("CfgReady after swap", bus.CfgReady, 1);
    waitTick("div1 tick", t2);
    chk("div1 period", t2 - t1, 4);

    loadDiv(3);
    waitTick("restore a", t0);
    waitTick("restore b", t0);

    // Full window of 3 periods.
    pulseStart(3);
    gateWindow(-5, len, dn, rs);
    chk("win3 gate length", len, 24);
    chk("win3 Done at fall", dn, 1);
    chk("win3 TickCount", bus.TickCount, 3);
    chk("win3 CfgReady during gate", rs, 0);

    // Abort after two counted periods.
    pulseStart(5);
    waitGate(1'b1, "abort window open");
    waitTick("abort t1", t0);
    waitTick("abort t2", t0);
    @(negedge Clk);
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    chk("abort Gate", bus.Gate, 0);
    chk("abort Done", bus.Done, 0);
    chk("abort TickCount", bus.TickCount, 2);
    chk("abort Busy", bus.Busy, 0);
    pulseStart(1);
    chk("restart Busy", bus.Busy, 1);
    gateWindow(-5, len, dn, rs);
    chk("win1 gate length", len, 8);
    chk("win1 Done", dn, 1);

    // Zero-length Start ignored; Start during RUN ignored.
    pulseStart(0);
    chk("zero Start Busy", bus.Busy, 0);
    pulseStart(2);
    gateWindow(3, len, dn, rs);
    chk("win2 gate length", len, 16);
    chk("win2 TickCount", bus.TickCount, 2);

    // Async reset mid-RUN under a non-default divisor.
    loadDiv(1);
    waitTick("pre-reset a", t0);
    waitTick("pre-reset b", t0);
    pulseStart(4);
    waitGate(1'b1, "reset window open");
    repeat (3) @(negedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    chk("async reset Gate", bus.Gate, 0);
    chk("async reset ClkOut", bus.ClkOut, 0);
    chk("async reset Busy", bus.Busy, 0);
    chk("async reset TickCount", bus.TickCount, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    measurePeriod("post-reset period", per, hi);
    chk("post-reset period", per, 8);
    chk("post-reset high cycles", hi, 4);

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      bus.CfgValid = ($urandom_range(0, 7) == 0);
      bus.CfgDiv   = CNT_W'($urandom_range(0, 4));
      bus.Start    = ($urandom_range(0, 9) == 0);
      bus.WinTicks = WIN_W'($urandom_range(0, 3));
      bus.Abort    = ($urandom_range(0, 39) == 0);
    end
    @(negedge Clk);
    bus.CfgValid = 0; bus.Start = 0; bus.Abort = 0;
    repeat (5) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
